// File: rtl/pcie_recv.sv
// rtl/pcie_recv.sv - two-lane receiver sorting words into VC FIFOs and merging with VC0 priority; PCIE_RECV_RR_EN selects round-robin lane arbitration

module pcie_recv_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_wr,
  input  logic [W-1:0]            i_wdata,
  input  logic                    i_rd,
  output logic [W-1:0]            o_head,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [$clog2(DEPTH):0]  o_count_next,
  output logic                    o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  // fullness is judged on the pre-edge count, so a same-cycle read never frees room for a write
  assign o_full       = (r_count == CW'(DEPTH));
  assign w_wr         = i_wr && !o_full;
  assign w_rd         = i_rd && (r_count != '0);
  assign o_head       = r_mem[r_rptr];
  assign o_count      = r_count;
  assign o_count_next = i_clear ? '0 : (r_count + CW'(w_wr) - CW'(w_rd));

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= o_count_next;
    end
  end

  // storage array, no reset needed since occupancy guards every read
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end
endmodule

module pcie_recv #(
  parameter int LANE_DEPTH = 4,
  parameter int VC_DEPTH   = 8,
  parameter int LANE_HI    = 3
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       init,
  input  logic [5:0] data_in0,
  input  logic       push0,
  input  logic [5:0] data_in1,
  input  logic       push1,
  input  logic       pop,
  output logic [5:0] data_out,
  output logic       valid_out,
  output logic       pause0,
  output logic       pause1,
  output logic       active_out,
  output logic       idle_out,
  output logic       error_out
);
  localparam int LCW = $clog2(LANE_DEPTH) + 1;
  localparam int VCW = $clog2(VC_DEPTH) + 1;

  typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [5:0]     r_data_out;
  logic           r_valid_out;
  logic           r_pause0;
  logic           r_pause1;

  logic           w_run;
  logic           w_clear;
  logic [5:0]     w_l0_head, w_l1_head, w_vc0_head, w_vc1_head;
  logic [LCW-1:0] w_l0_cnt, w_l1_cnt, w_l0_cnt_next, w_l1_cnt_next;
  logic [VCW-1:0] w_vc0_cnt, w_vc1_cnt, w_vc0_cnt_next, w_vc1_cnt_next;
  logic           w_l0_full, w_l1_full, w_vc0_full, w_vc1_full;
  logic           w_elig0, w_elig1, w_gnt0, w_gnt1;
  logic           w_xfer;
  logic [5:0]     w_xfer_data;
  logic           w_pop_vc0, w_pop_vc1, w_pop_empty;
  logic           w_err;
  logic           w_any_next;

  // traffic only flows in the operational states; init takes precedence over everything else
  assign w_run   = ((r_state == S_IDLE) || (r_state == S_ACTIVE) || (r_state == S_ERROR)) && !init;
  assign w_clear = init && (r_state != S_RESET);

  pcie_recv_fifo #(.DEPTH(LANE_DEPTH), .W(6)) u_lane0 (
    .clk(clk), .i_rst(reset_L), .i_clear(w_clear),
    .i_wr(w_run && push0), .i_wdata(data_in0), .i_rd(w_gnt0),
    .o_head(w_l0_head), .o_count(w_l0_cnt), .o_count_next(w_l0_cnt_next), .o_full(w_l0_full)
  );

  pcie_recv_fifo #(.DEPTH(LANE_DEPTH), .W(6)) u_lane1 (
    .clk(clk), .i_rst(reset_L), .i_clear(w_clear),
    .i_wr(w_run && push1), .i_wdata(data_in1), .i_rd(w_gnt1),
    .o_head(w_l1_head), .o_count(w_l1_cnt), .o_count_next(w_l1_cnt_next), .o_full(w_l1_full)
  );

  pcie_recv_fifo #(.DEPTH(VC_DEPTH), .W(6)) u_vc0 (
    .clk(clk), .i_rst(reset_L), .i_clear(w_clear),
    .i_wr(w_xfer && !w_xfer_data[4]), .i_wdata(w_xfer_data), .i_rd(w_pop_vc0),
    .o_head(w_vc0_head), .o_count(w_vc0_cnt), .o_count_next(w_vc0_cnt_next), .o_full(w_vc0_full)
  );

  pcie_recv_fifo #(.DEPTH(VC_DEPTH), .W(6)) u_vc1 (
    .clk(clk), .i_rst(reset_L), .i_clear(w_clear),
    .i_wr(w_xfer && w_xfer_data[4]), .i_wdata(w_xfer_data), .i_rd(w_pop_vc1),
    .o_head(w_vc1_head), .o_count(w_vc1_cnt), .o_count_next(w_vc1_cnt_next), .o_full(w_vc1_full)
  );

  // a lane head may move only if its target VC has room before this edge
  assign w_elig0 = w_run && (w_l0_cnt != '0) && !(w_l0_head[4] ? w_vc1_full : w_vc0_full);
  assign w_elig1 = w_run && (w_l1_cnt != '0) && !(w_l1_head[4] ? w_vc1_full : w_vc0_full);

`ifdef PCIE_RECV_RR_EN
  logic r_prio1;

  // the lane granted last yields the next tie; survives init, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset_L) begin
      r_prio1 <= 1'b0;
    end else if (w_gnt0) begin
      r_prio1 <= 1'b1;
    end else if (w_gnt1) begin
      r_prio1 <= 1'b0;
    end
  end

  assign w_gnt0 = w_elig0 && (!w_elig1 || !r_prio1);
`else
  assign w_gnt0 = w_elig0;
`endif
  assign w_gnt1      = w_elig1 && !w_gnt0;
  assign w_xfer      = w_gnt0 || w_gnt1;
  assign w_xfer_data = w_gnt1 ? w_l1_head : w_l0_head;

  // VC0 strictly ahead of VC1; a word arriving this cycle is not visible until next
  assign w_pop_vc0   = w_run && pop && (w_vc0_cnt != '0);
  assign w_pop_vc1   = w_run && pop && (w_vc0_cnt == '0) && (w_vc1_cnt != '0);
  assign w_pop_empty = w_run && pop && (w_vc0_cnt == '0) && (w_vc1_cnt == '0);

  assign w_err = (w_run && push0 && w_l0_full) || (w_run && push1 && w_l1_full) || w_pop_empty;

  assign w_any_next = (w_l0_cnt_next != '0) || (w_l1_cnt_next != '0) ||
                      (w_vc0_cnt_next != '0) || (w_vc1_cnt_next != '0);

  // merged output word and its valid flag
  always_ff @(posedge clk) begin
    if (reset_L) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_pop_vc0 || w_pop_vc1;
      if (w_pop_vc0) begin
        r_data_out <= w_vc0_head;
      end else if (w_pop_vc1) begin
        r_data_out <= w_vc1_head;
      end
    end
  end

  // back-pressure reflects lane occupancy after this edge
  always_ff @(posedge clk) begin
    if (reset_L) begin
      r_pause0 <= 1'b0;
      r_pause1 <= 1'b0;
    end else begin
      r_pause0 <= (w_l0_cnt_next >= LCW'(LANE_HI));
      r_pause1 <= (w_l1_cnt_next >= LCW'(LANE_HI));
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset_L) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: init beats error, error beats normal flow
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:           w_state_next = S_INIT;
      S_INIT:            w_state_next = S_IDLE;
      S_IDLE, S_ACTIVE:  w_state_next = w_any_next ? S_ACTIVE : S_IDLE;
      S_ERROR:           w_state_next = S_ERROR;
      default:           w_state_next = S_RESET;
    endcase
    if (w_clear) begin
      w_state_next = S_INIT;
    end else if (w_err) begin
      w_state_next = S_ERROR;
    end
  end

  // FSM status decode straight from the state register
  always_comb begin
    active_out = 1'b0;
    idle_out   = 1'b0;
    error_out  = 1'b0;
    case (r_state)
      S_ACTIVE: active_out = 1'b1;
      S_IDLE:   idle_out   = 1'b1;
      S_ERROR:  error_out  = 1'b1;
      default:  ;
    endcase
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign pause0    = r_pause0;
  assign pause1    = r_pause1;
endmodule

// File: tb/tb_pcie_recv.sv
// tb/tb_pcie_recv.sv - self-checking bench for pcie_recv against a queue-based reference model

module tb_pcie_recv;
  logic       clk = 1'b0;
  logic       reset_L, init, push0, push1, pop;
  logic [5:0] data_in0, data_in1;
  logic [5:0] data_out;
  logic       valid_out, pause0, pause1, active_out, idle_out, error_out;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pcie_recv dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .data_in0(data_in0), .push0(push0), .data_in1(data_in1), .push1(push1),
    .pop(pop), .data_out(data_out), .valid_out(valid_out),
    .pause0(pause0), .pause1(pause1),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
  );

`ifdef PCIE_RECV_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  int         m_state;
  logic [5:0] lq0[$], lq1[$], vq0[$], vq1[$];
  logic [5:0] m_dout;
  logic       m_valid, m_p0, m_p1;
  int         m_last;

  wire [12:0] w_dut_vec = {data_out, valid_out, pause0, pause1, active_out, idle_out, error_out};

  function automatic logic [12:0] m_vec();
    return {m_dout, m_valid, m_p0, m_p1, (m_state == M_ACTIVE), (m_state == M_IDLE), (m_state == M_ERROR)};
  endfunction

  task automatic model_edge();
    int s_l0, s_l1, s_v0, s_v1, g;
    bit run, clr, err, e0, e1;
    logic [5:0] w;
    if (reset_L) begin
      lq0.delete(); lq1.delete(); vq0.delete(); vq1.delete();
      m_state = M_RESET; m_dout = '0; m_valid = 1'b0; m_p0 = 1'b0; m_p1 = 1'b0; m_last = 1;
      return;
    end
    run = (m_state == M_IDLE || m_state == M_ACTIVE || m_state == M_ERROR) && !init;
    clr = init && (m_state != M_RESET);
    err = 1'b0;
    m_valid = 1'b0;
    if (clr) begin
      lq0.delete(); lq1.delete(); vq0.delete(); vq1.delete();
    end else if (run) begin
      s_l0 = lq0.size(); s_l1 = lq1.size(); s_v0 = vq0.size(); s_v1 = vq1.size();
      if (pop) begin
        if (s_v0 > 0) begin m_dout = vq0.pop_front(); m_valid = 1'b1; end
        else if (s_v1 > 0) begin m_dout = vq1.pop_front(); m_valid = 1'b1; end
        else err = 1'b1;
      end
      e0 = 1'b0; e1 = 1'b0;
      if (s_l0 > 0) begin w = lq0[0]; e0 = w[4] ? (s_v1 < 8) : (s_v0 < 8); end
      if (s_l1 > 0) begin w = lq1[0]; e1 = w[4] ? (s_v1 < 8) : (s_v0 < 8); end
      g = -1;
      if (e0 && e1) g = RR ? ((m_last == 1) ? 0 : 1) : 0;
      else if (e0) g = 0;
      else if (e1) g = 1;
      if (g == 0) begin w = lq0.pop_front(); m_last = 0; end
      if (g == 1) begin w = lq1.pop_front(); m_last = 1; end
      if (g >= 0) begin
        if (w[4]) vq1.push_back(w); else vq0.push_back(w);
      end
      if (push0) begin if (s_l0 >= 4) err = 1'b1; else lq0.push_back(data_in0); end
      if (push1) begin if (s_l1 >= 4) err = 1'b1; else lq1.push_back(data_in1); end
    end
    m_p0 = (lq0.size() >= 3);
    m_p1 = (lq1.size() >= 3);
    if (clr) m_state = M_INIT;
    else if (err) m_state = M_ERROR;
    else if (m_state == M_RESET) m_state = M_INIT;
    else if (m_state == M_INIT) m_state = M_IDLE;
    else if (m_state == M_IDLE || m_state == M_ACTIVE)
      m_state = (lq0.size() + lq1.size() + vq0.size() + vq1.size() > 0) ? M_ACTIVE : M_IDLE;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    push0 = 1'b0; push1 = 1'b0; pop = 1'b0; init = 1'b0;
    data_in0 = '0; data_in1 = '0;
  endtask

  task automatic bring_up();
    quiet();
    reset_L = 1'b1; tick(); tick();
    reset_L = 1'b0; init = 1'b1; tick();
    init = 1'b0; tick();
  endtask

  task automatic test_reset();
    quiet();
    reset_L = 1'b1; tick(); tick();
    total++; if (w_dut_vec !== 13'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", w_dut_vec, 13'h0); end
    total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL reset_model got=%h exp=%h", w_dut_vec, m_vec()); end
    reset_L = 1'b0; tick();
    total++; if (w_dut_vec !== 13'h0) begin bad++; $display("FAIL reset_init_state got=%h exp=%h", w_dut_vec, 13'h0); end
    init = 1'b1; tick();
    init = 1'b0; tick();
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL reset_to_idle got=%b exp=1", idle_out); end
  endtask

  task automatic test_single_word();
    push0 = 1'b1; data_in0 = 6'h05; tick();
    total++; if (active_out !== 1'b1) begin bad++; $display("FAIL single_active got=%b exp=1", active_out); end
    push0 = 1'b0; tick();
    total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL single_model got=%h exp=%h", w_dut_vec, m_vec()); end
    pop = 1'b1; tick();
    total++; if (data_out !== 6'h05 || valid_out !== 1'b1) begin bad++; $display("FAIL single_pop got=%h/%b exp=05/1", data_out, valid_out); end
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", idle_out); end
    pop = 1'b0; tick();
    total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL single_after got=%h exp=%h", w_dut_vec, m_vec()); end
  endtask

  task automatic test_vc_priority();
    push0 = 1'b1; data_in0 = 6'h12; push1 = 1'b1; data_in1 = 6'h03; tick();
    push0 = 1'b0; push1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL vcprio_wait got=%h exp=%h", w_dut_vec, m_vec()); end
    end
    pop = 1'b1; tick();
    total++; if (data_out !== 6'h03 || valid_out !== 1'b1) begin bad++; $display("FAIL vcprio_first got=%h/%b exp=03/1", data_out, valid_out); end
    tick();
    total++; if (data_out !== 6'h12 || valid_out !== 1'b1) begin bad++; $display("FAIL vcprio_second got=%h/%b exp=12/1", data_out, valid_out); end
    pop = 1'b0; tick();
    total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL vcprio_after got=%h exp=%h", w_dut_vec, m_vec()); end
  endtask

  task automatic test_empty_pop();
    logic [5:0] prev;
    prev = m_dout;
    pop = 1'b1; tick();
    total++; if (valid_out !== 1'b0 || data_out !== prev) begin bad++; $display("FAIL emptypop_data got=%h/%b exp=%h/0", data_out, valid_out, prev); end
    total++; if (error_out !== 1'b1) begin bad++; $display("FAIL emptypop_error got=%b exp=1", error_out); end
    pop = 1'b0; tick();
    total++; if (error_out !== 1'b1) begin bad++; $display("FAIL emptypop_sticky got=%b exp=1", error_out); end
    init = 1'b1; tick();
    init = 1'b0; tick();
    total++; if (idle_out !== 1'b1 || error_out !== 1'b0) begin bad++; $display("FAIL emptypop_recover got=%b/%b exp=1/0", idle_out, error_out); end
  endtask

  task automatic test_overflow();
    push0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in0 = 6'($urandom) & 6'h2F; tick();
      total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL ovf_fill got=%h exp=%h", w_dut_vec, m_vec()); end
    end
    push0 = 1'b0; tick();
    push0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      data_in0 = 6'($urandom) & 6'h2F; tick();
      total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL ovf_model k=%0d got=%h exp=%h", k, w_dut_vec, m_vec()); end
      if (k == 2) begin total++; if (pause0 !== 1'b0) begin bad++; $display("FAIL ovf_pause_lo got=%b exp=0", pause0); end end
      if (k == 3) begin total++; if (pause0 !== 1'b1) begin bad++; $display("FAIL ovf_pause_hi got=%b exp=1", pause0); end end
      if (k == 4) begin total++; if (error_out !== 1'b0) begin bad++; $display("FAIL ovf_no_err got=%b exp=0", error_out); end end
      if (k == 5) begin total++; if (error_out !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", error_out); end end
    end
    push0 = 1'b0; init = 1'b1; tick();
    init = 1'b0; tick();
    total++; if (idle_out !== 1'b1 || pause0 !== 1'b0) begin bad++; $display("FAIL ovf_recover got=%b/%b exp=1/0", idle_out, pause0); end
  endtask

  task automatic test_arbitration();
    logic [5:0] exp_order [6];
    if (RR) begin
      exp_order[0] = 6'h00; exp_order[1] = 6'h20; exp_order[2] = 6'h01;
      exp_order[3] = 6'h21; exp_order[4] = 6'h02; exp_order[5] = 6'h22;
    end else begin
      exp_order[0] = 6'h00; exp_order[1] = 6'h01; exp_order[2] = 6'h02;
      exp_order[3] = 6'h20; exp_order[4] = 6'h21; exp_order[5] = 6'h22;
    end
    bring_up();
    for (int i = 0; i < 3; i++) begin
      push0 = 1'b1; data_in0 = 6'(i); push1 = 1'b1; data_in1 = 6'(32 + i); tick();
      total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL arb_push got=%h exp=%h", w_dut_vec, m_vec()); end
    end
    push0 = 1'b0; push1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    pop = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      total++; if (data_out !== exp_order[j] || valid_out !== 1'b1) begin bad++; $display("FAIL arb_order j=%0d got=%h/%b exp=%h/1", j, data_out, valid_out, exp_order[j]); end
      total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL arb_model got=%h exp=%h", w_dut_vec, m_vec()); end
    end
    pop = 1'b0; tick();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      push0 = 1'b1; push1 = 1'b1; data_in0 = 6'($urandom); data_in1 = 6'($urandom); tick();
    end
    push0 = 1'b0; push1 = 1'b0;
    reset_L = 1'b1; tick();
    total++; if (w_dut_vec !== 13'h0) begin bad++; $display("FAIL midreset_outputs got=%h exp=%h", w_dut_vec, 13'h0); end
    reset_L = 1'b0; pop = 1'b1; tick();
    total++; if (valid_out !== 1'b0 || error_out !== 1'b0) begin bad++; $display("FAIL midreset_pop got=%b/%b exp=0/0", valid_out, error_out); end
    pop = 1'b0; tick();
    total++; if (w_dut_vec !== m_vec() || idle_out !== 1'b1) begin bad++; $display("FAIL midreset_idle got=%h exp=%h", w_dut_vec, m_vec()); end
  endtask

  task automatic test_random();
    bring_up();
    for (int n = 0; n < 3000; n++) begin
      reset_L  = ($urandom_range(0, 299) == 0);
      init     = ($urandom_range(0, 47) == 0);
      push0    = ($urandom_range(0, 99) < 45);
      push1    = ($urandom_range(0, 99) < 45);
      pop      = ($urandom_range(0, 99) < 50);
      data_in0 = 6'($urandom);
      data_in1 = 6'($urandom);
      tick();
      total++; if (w_dut_vec !== m_vec()) begin bad++; $display("FAIL random n=%0d got=%h exp=%h", n, w_dut_vec, m_vec()); end
    end
    quiet();
    reset_L = 1'b0;
  endtask

  initial begin
    quiet();
    reset_L = 1'b1;
    test_reset();
    test_single_word();
    test_vc_priority();
    test_empty_pop();
    test_overflow();
    test_arbitration();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcie_recv.md
# pcie_recv

Receive-side counterpart of the PCIE transmit path. It accepts 6-bit words from the two downstream lanes (D0, D1) into per-lane FIFOs and sorts them by virtual channel into VC0/VC1 FIFOs. It then merges them back into a single output stream, with VC0 taking strict priority over VC1. It drives per-lane pause back to the transmitter and reports status through the active/idle/error FSM convention used by the transmit side.

## Interface
- `LANE_DEPTH`, default 4: entries per lane FIFO (power of 2).
- `VC_DEPTH`, default 8: entries per VC FIFO (power of 2).
- `LANE_HI`, default 3: lane occupancy at or above which that lane's pause asserts.
- `clk`, in, 1: clock; all state updates on rising edge.
- `reset_L`, in, 1: reset; synchronous, active-high (1 = reset), despite the `_L` suffix.
- `init`, in, 1: synchronous soft clear of FIFOs and error state.
- `data_in0`, in, 6: lane D0 word; bit 4 selects VC (0 = VC0, 1 = VC1).
- `push0`, in, 1: write `data_in0` this cycle.
- `data_in1`, in, 6: lane D1 word; same format.
- `push1`, in, 1: write `data_in1` this cycle.
- `pop`, in, 1: downstream requests one word.
- `data_out`, out, 6: registered output word.
- `valid_out`, out, 1: `data_out` holds a word popped at the last edge.
- `pause0`, out, 1: lane D0 occupancy ≥ `LANE_HI`.
- `pause1`, out, 1: lane D1 occupancy ≥ `LANE_HI`.
- `active_out`, out, 1: FSM in ACTIVE.
- `idle_out`, out, 1: FSM in IDLE.
- `error_out`, out, 1: FSM in ERROR.

## Operation
- **Lane FIFOs.** Each lane FIFO is circular, with pointers wrapping modulo the depth. The count is log2(depth)+1 bits.
  - A push to a lane that is full at the start of the cycle is dropped and raises an error.
  - This holds even if a transfer empties a slot in the same cycle.
- **Transfer stage.** At most one word moves from a lane head to a VC FIFO per cycle.
  - A lane is eligible when it is non-empty and its head's VC FIFO count is below `VC_DEPTH`, judged on pre-edge counts.
  - When both lanes are eligible, arbitration is round-robin per `PCIE_RECV_RR_EN`.
  - An ineligible head blocks only its own lane. There is no reordering within a lane.
- **Output stage.**
  - When `pop`=1 and VC0 is non-empty, the VC0 head goes to `data_out`.
  - Otherwise, when `pop`=1 and VC1 is non-empty, the VC1 head goes to `data_out`.
  - Otherwise, if `pop`=1 with both VCs empty (pre-edge), `valid_out` is 0, `data_out` holds its value, and an error is raised.
  - A word transferred into a VC in the same cycle is not poppable until the next cycle.
- **Simultaneous push, transfer and pop** on the same FIFO are allowed. Counts update as count + in − out.
- **FSM** states are RESET, INIT, IDLE, ACTIVE, ERROR.
  - RESET → INIT on reset release.
  - INIT → IDLE when `init`=0.
  - IDLE ↔ ACTIVE on whether any FIFO is non-empty.
  - Any state → ERROR on an error event. ERROR is sticky.
  - ERROR → INIT when `init`=1.
  - `init`=1 in any non-RESET state → INIT, and all FIFOs are cleared.
  - While in INIT, pushes and pops are ignored with no error.
- **Outputs at reset.** `data_out`=0, `valid_out`=0, `pause0`=0, `pause1`=0, `active_out`=0, `idle_out`=0, `error_out`=0. All pointers, counts and the arbiter are cleared, and the arbiter favours lane 0 first.

## Timing
- A push sampled at edge N is written at edge N.
- The earliest transfer to a VC is at edge N+1.
- The earliest pop is sampled at edge N+2. `data_out`/`valid_out` update at that edge.
- Minimum latency is therefore 2 cycles from push to output.
- `pause0`/`pause1` are registered and reflect the occupancy after edge N.
- FSM outputs are registered and reflect the state entered at the same edge.
- Reset asserted mid-operation clears everything at the next edge. In-flight words are lost.

## Configuration
- **`PCIE_RECV_RR_EN` defined:** lane arbitration is round-robin.
  - The lane granted last has lower priority next time both lanes are eligible.
- **`PCIE_RECV_RR_EN` not defined:** fixed priority; lane 0 always wins when both lanes are eligible.

## Test plan
- **Single word:** reset, then `init` pulse, then push0 `6'h05` (VC0) → `pop` two cycles later gives `data_out`=`6'h05`, `valid_out`=1, `active_out`=1 then `idle_out`=1.
- **VC priority:** push `6'h12` (VC1) on lane 0 and `6'h03` (VC0) on lane 1 in the same cycle, wait 3 cycles, pop twice → `6'h03` then `6'h12`.
- **Lane overflow:** push0 for 5 consecutive cycles with `pop`=0 and VC0 held full → `pause0`=1 once occupancy reaches 3, the 5th push is dropped, `error_out`=1 the next cycle, and a later `init` returns the FSM to IDLE.
- **Empty pop:** `pop`=1 with all FIFOs empty → `valid_out`=0, `data_out` unchanged, `error_out`=1.
- **Arbitration:** keep both lanes continuously non-empty with VC0 words → with `PCIE_RECV_RR_EN` the VC writes alternate L0, L1, L0, …; without it, L0 drains first.
- **Reset mid-stream:** assert `reset_L`=1 with 6 words buffered → next cycle all counts are 0, all outputs are 0, and a pop gives no valid word.
